rega_scheduler: RTL and testbench

//  Sequencing FSM for the irrigation datapath. Shares the water line between the sprinkler
//  (asp) and drip (got) requesters, and inserts the mandatory line-cleaning and fertilizer
//  (aduba) phases. Drives rega/limpeza/estado so downstream validation never flags an error.

---
 rtl/rega_scheduler.sv | 140 ++++++++++++++
 tb/tb_rega_scheduler.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/rega_scheduler.sv
// Irrigation sequencing FSM: arbitrates the water line between sprinkler and drip,
// and inserts the cleaning and fertilizer phases. All outputs are registered.
module rega_scheduler #(
  parameter int TW           = 16,
  parameter int REGA_CYCLES  = 100,
  parameter int LIMP_CYCLES  = 20,
  parameter int ADUBA_CYCLES = 30
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_asp,
  input  logic       req_got,
  input  logic       req_aduba,
  input  logic       critico,
  input  logic       VE,
  input  logic       clr_erro,
  output logic [1:0] rega,
  output logic [1:0] limpeza,
  output logic [1:0] estado,
  output logic       erro,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REGA,
    S_LIMPEZA,
    S_ADUBA,
    S_ERRO
  } state_t;

  localparam logic [TW-1:0] REGA_LOAD  = TW'(REGA_CYCLES - 1);
  localparam logic [TW-1:0] LIMP_LOAD  = TW'(LIMP_CYCLES - 1);
  localparam logic [TW-1:0] ADUBA_LOAD = TW'(ADUBA_CYCLES - 1);

  state_t        state_reg, state_next;
  logic [TW-1:0] cnt_reg, cnt_next;
  logic          src_asp_reg, src_asp_next;    // 1 = sprinkler, 0 = drip
  logic          last_asp_reg, last_asp_next;
  logic          ok;
  logic          pick_asp;
  logic [1:0]    rega_next, limpeza_next, estado_next;
  logic          erro_next, busy_next;

  assign ok = critico & ~VE;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    src_asp_next  = src_asp_reg;
    last_asp_next = last_asp_reg;
    pick_asp      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if ((req_asp | req_got) && ok) begin
          // On a tie, serve whichever requester was not served last.
          pick_asp      = (req_asp && req_got) ? ~last_asp_reg : req_asp;
          state_next    = S_REGA;
          cnt_next      = REGA_LOAD;
          src_asp_next  = pick_asp;
          last_asp_next = pick_asp;
        end else if (req_aduba) begin
          state_next = S_ADUBA;
          cnt_next   = ADUBA_LOAD;
        end
      end
      S_REGA: begin
        if (!ok) begin
          state_next = S_ERRO;
        end else if (cnt_reg == '0) begin
          state_next = S_LIMPEZA;
          cnt_next   = LIMP_LOAD;
        end else begin
          cnt_next = cnt_reg - TW'(1);
        end
      end
      S_LIMPEZA, S_ADUBA: begin
        if (cnt_reg == '0) state_next = S_IDLE;
        else               cnt_next   = cnt_reg - TW'(1);
      end
      S_ERRO: begin
        if (clr_erro && ok) begin
          state_next = S_LIMPEZA;
          cnt_next   = LIMP_LOAD;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode of the next state, registered alongside it.
  always_comb begin
    rega_next    = 2'b00;
    limpeza_next = 2'b00;
    estado_next  = 2'b00;
    erro_next    = 1'b0;
    busy_next    = (state_next != S_IDLE);
    case (state_next)
      S_REGA: begin
        rega_next   = src_asp_next ? 2'b10 : 2'b01;
        estado_next = 2'b11;
      end
      S_LIMPEZA: begin
        limpeza_next = 2'b10;
        estado_next  = 2'b10;
      end
      S_ADUBA: begin
        limpeza_next = 2'b01;
        estado_next  = 2'b01;
      end
      S_ERRO:  erro_next = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      src_asp_reg  <= 1'b0;
      last_asp_reg <= 1'b0;
      rega         <= 2'b00;
      limpeza      <= 2'b00;
      estado       <= 2'b00;
      erro         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      src_asp_reg  <= src_asp_next;
      last_asp_reg <= last_asp_next;
      rega         <= rega_next;
      limpeza      <= limpeza_next;
      estado       <= estado_next;
      erro         <= erro_next;
      busy         <= busy_next;
    end
  end

endmodule

// File: tb/tb_rega_scheduler.sv
// Scoreboard bench for rega_scheduler: stimulus pushes expected outputs per edge,
// a monitor pops and compares shortly after each rising edge.
module tb_rega_scheduler;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_asp, req_got, req_aduba, critico, VE, clr_erro;
  logic [1:0] rega, limpeza, estado;
  logic       erro, busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      name;
    logic [1:0] rega;
    logic [1:0] limpeza;
    logic [1:0] estado;
    logic       erro;
  } exp_t;

  exp_t exp_q[$];

  rega_scheduler #(
    .TW(16), .REGA_CYCLES(4), .LIMP_CYCLES(2), .ADUBA_CYCLES(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_asp(req_asp), .req_got(req_got),
    .req_aduba(req_aduba), .critico(critico), .VE(VE), .clr_erro(clr_erro),
    .rega(rega), .limpeza(limpeza), .estado(estado), .erro(erro), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  // Monitor: one line per transaction, compared against the queued expectation.
  always @(posedge clk) begin
    #1;
    if (reset_n && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      $display("t=%0t %s rega=%b limpeza=%b estado=%b erro=%b busy=%b",
               $time, e.name, rega, limpeza, estado, erro, busy);
      chk({e.name, ".rega"}, rega, e.rega);
      chk({e.name, ".limpeza"}, limpeza, e.limpeza);
      chk({e.name, ".estado"}, estado, e.estado);
      chk({e.name, ".erro"}, {1'b0, erro}, {1'b0, e.erro});
      chk({e.name, ".busy"}, {1'b0, busy}, {1'b0, (e.estado != 2'b00) | e.erro});
      if (rega == 2'b11) chk({e.name, ".rega_onehot"}, rega, 2'b00);
      if (limpeza == 2'b11) chk({e.name, ".limpeza_not11"}, limpeza, 2'b00);
    end
  end

  task automatic step(input string name, input logic a, input logic g, input logic ad,
                      input logic cr, input logic ve, input logic clr,
                      input logic [1:0] er, input logic [1:0] el, input logic [1:0] ee,
                      input logic eerr);
    exp_t e;
    @(negedge clk);
    req_asp = a; req_got = g; req_aduba = ad; critico = cr; VE = ve; clr_erro = clr;
    e.name = name; e.rega = er; e.limpeza = el; e.estado = ee; e.erro = eerr;
    exp_q.push_back(e);
  endtask

  initial begin
    reset_n = 1'b0;
    req_asp = 0; req_got = 0; req_aduba = 0; critico = 1; VE = 0; clr_erro = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    step("rst_idle", 0,0,0,1,0,0, 2'b00,2'b00,2'b00,0);

    // Single sprinkler request: 4 REGA, 2 LIMPEZA, then idle.
    step("t2_rega", 1,0,0,1,0,0, 2'b10,2'b00,2'b11,0);
    repeat (3) step("t2_rega", 0,0,0,1,0,0, 2'b10,2'b00,2'b11,0);
    repeat (2) step("t2_limp", 0,0,0,1,0,0, 2'b00,2'b10,2'b10,0);
    step("t2_idle", 0,0,0,1,0,0, 2'b00,2'b00,2'b00,0);

    // Async reset mid-REGA.
    step("t1_rega", 1,0,0,1,0,0, 2'b10,2'b00,2'b11,0);
    step("t1_rega", 0,0,0,1,0,0, 2'b10,2'b00,2'b11,0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t1_async.rega", rega, 2'b00);
    chk("t1_async.limpeza", limpeza, 2'b00);
    chk("t1_async.estado", estado, 2'b00);
    chk("t1_async.erro_busy", {erro, busy}, 2'b00);
    @(negedge clk);
    reset_n = 1'b1;

    // Held tie after reset: asp, got, asp.
    for (int k = 0; k < 3; k++) begin
      logic [1:0] src;
      src = (k == 1) ? 2'b01 : 2'b10;
      repeat (4) step("t3_rega", 1,1,0,1,0,0, src,2'b00,2'b11,0);
      if (k < 2) begin
        repeat (2) step("t3_limp", 1,1,0,1,0,0, 2'b00,2'b10,2'b10,0);
        step("t3_idle", 1,1,0,1,0,0, 2'b00,2'b00,2'b00,0);
      end
    end
    repeat (2) step("t3_limp", 0,0,0,1,0,0, 2'b00,2'b10,2'b10,0);
    step("t3_idle", 0,0,0,1,0,0, 2'b00,2'b00,2'b00,0);

    // VE abort, ignored clear, accepted clear.
    step("t4_rega", 1,0,0,1,0,0, 2'b10,2'b00,2'b11,0);
    step("t4_rega", 0,0,0,1,0,0, 2'b10,2'b00,2'b11,0);
    step("t4_erro", 0,0,0,1,1,0, 2'b00,2'b00,2'b00,1);
    step("t4_clr_ve", 0,0,0,1,1,1, 2'b00,2'b00,2'b00,1);
    step("t4_erro", 0,0,0,1,0,0, 2'b00,2'b00,2'b00,1);
    step("t4_clr_ok", 0,0,0,1,0,1, 2'b00,2'b10,2'b10,0);
    step("t4_limp", 0,0,0,1,0,0, 2'b00,2'b10,2'b10,0);
    step("t4_idle", 0,0,0,1,0,0, 2'b00,2'b00,2'b00,0);

    // Low water: fertilizer served while drip waits.
    step("t5_aduba", 0,1,1,0,0,0, 2'b00,2'b01,2'b01,0);
    repeat (2) step("t5_aduba", 0,1,0,0,0,0, 2'b00,2'b01,2'b01,0);
    step("t5_idle", 0,1,0,0,0,0, 2'b00,2'b00,2'b00,0);
    step("t5_got", 0,1,0,1,0,0, 2'b01,2'b00,2'b11,0);
    repeat (3) step("t5_got", 0,0,0,1,0,0, 2'b01,2'b00,2'b11,0);
    repeat (2) step("t5_limp", 0,0,0,1,0,0, 2'b00,2'b10,2'b10,0);
    step("t5_idle", 0,0,0,1,0,0, 2'b00,2'b00,2'b00,0);

    // Abort on the same edge the REGA counter expires.
    step("t6_rega", 1,0,0,1,0,0, 2'b10,2'b00,2'b11,0);
    repeat (3) step("t6_rega", 0,0,0,1,0,0, 2'b10,2'b00,2'b11,0);
    step("t6_erro", 0,0,0,1,1,0, 2'b00,2'b00,2'b00,1);
    step("t6_clr", 0,0,0,1,0,1, 2'b00,2'b10,2'b10,0);
    step("t6_limp", 0,0,0,1,0,0, 2'b00,2'b10,2'b10,0);
    step("t6_idle", 0,0,0,1,0,0, 2'b00,2'b00,2'b00,0);

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    chk("queue_drained", (exp_q.size() == 0) ? 2'b01 : 2'b00, 2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
